// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: word loads/stores on a resettable data array,
// with fault detection that suppresses side effects, feeding the MEM/WB register.
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl_mem,
  input  logic [31:0] rd_mem,
  input  logic [31:0] pc4_mem,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data1,
  output logic [2:0]  ctrl_wb,
  output logic [31:0] rd_wb,
  output logic [31:0] pc4_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] mem_data_wb,
  output logic [1:0]  fault_wb
);

  localparam int TAG_LSB = ADDR_W + 2;

  logic              reg_write_s;
  logic [1:0]        wb_sel_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              access_s;
  logic [1:0]        fault_s;
  logic              store_en_s;
  logic [31:0]       rd_data_s;

  logic [31:0]       mem_q [DEPTH];

  logic [2:0]        ctrl_wb_d, ctrl_wb_q;
  logic [31:0]       rd_wb_d, rd_wb_q;
  logic [31:0]       pc4_wb_d, pc4_wb_q;
  logic [31:0]       alu_result_wb_d, alu_result_wb_q;
  logic [31:0]       mem_data_wb_d, mem_data_wb_q;
  logic [1:0]        fault_wb_d, fault_wb_q;

  // The reserved write-back select falls back to the ALU result.
  function automatic logic [1:0] wb_sel_map(input logic [1:0] sel);
    logic [1:0] res;
    case (sel)
      2'b11:   res = 2'b00;
      default: res = sel;
    endcase
    return res;
  endfunction

  // Fault vector {out_of_range, misaligned}, only meaningful for real accesses.
  function automatic logic [1:0] fault_vec(input logic acc, input logic oor, input logic mis);
    return {acc & oor, acc & mis};
  endfunction

  // Control field split and address decode.
  always_comb begin
    reg_write_s    = ctrl_mem[4];
    wb_sel_s       = ctrl_mem[3:2];
    mem_read_s     = ctrl_mem[1];
    mem_write_s    = ctrl_mem[0];
    word_idx_s     = alu_result[ADDR_W+1:2];
    misaligned_s   = (alu_result[1:0] != 2'b00);
    // Any set bit above the word index is out of range; addresses never alias.
    out_of_range_s = |alu_result[31:TAG_LSB];
    access_s       = mem_read_s | mem_write_s;
    fault_s        = fault_vec(access_s, out_of_range_s, misaligned_s);
    store_en_s     = mem_write_s & ~(|fault_s);
    rd_data_s      = mem_q[word_idx_s];
  end

  // MEM/WB next-state; the load sees pre-edge array contents.
  always_comb begin
    ctrl_wb_d       = {reg_write_s & ~(|fault_s), wb_sel_map(wb_sel_s)};
    rd_wb_d         = rd_mem;
    pc4_wb_d        = pc4_mem;
    alu_result_wb_d = alu_result;
    fault_wb_d      = fault_s;
    if (mem_read_s && (fault_s == 2'b00)) begin
      mem_data_wb_d = rd_data_s;
    end else begin
      mem_data_wb_d = 32'h0000_0000;
    end
  end

  // Data array: cleared asynchronously on reset, written only by non-faulting stores.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (store_en_s) begin
      mem_q[word_idx_s] <= write_data1;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_wb_q       <= 3'b000;
      rd_wb_q         <= 32'h0000_0000;
      pc4_wb_q        <= 32'h0000_0000;
      alu_result_wb_q <= 32'h0000_0000;
      mem_data_wb_q   <= 32'h0000_0000;
      fault_wb_q      <= 2'b00;
    end else begin
      ctrl_wb_q       <= ctrl_wb_d;
      rd_wb_q         <= rd_wb_d;
      pc4_wb_q        <= pc4_wb_d;
      alu_result_wb_q <= alu_result_wb_d;
      mem_data_wb_q   <= mem_data_wb_d;
      fault_wb_q      <= fault_wb_d;
    end
  end

  assign ctrl_wb       = ctrl_wb_q;
  assign rd_wb         = rd_wb_q;
  assign pc4_wb        = pc4_wb_q;
  assign alu_result_wb = alu_result_wb_q;
  assign mem_data_wb   = mem_data_wb_q;
  assign fault_wb      = fault_wb_q;

endmodule
